// File: rtl/pkt_fifo_pkg.sv
// Shared types and constants for the AXIS store-and-forward packet FIFO.
package pkt_fifo_pkg;

    typedef enum logic {
        W_PASS = 1'b0,
        W_DROP = 1'b1
    } wr_state_t;

    localparam int DROP_CNT_W = 16;

    // One extra pointer bit tells a full buffer apart from an empty one.
    function automatic int ptr_w(input int depth_log2);
        return depth_log2 + 1;
    endfunction

endpackage

// File: rtl/pkt_fifo_ram.sv
// Simple dual-port RAM with a registered read port, intended to map onto block RAM.
module pkt_fifo_ram #(
    parameter int WIDTH = 33,
    parameter int AW    = 10
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_mem [0:(1<<AW)-1];
    logic [WIDTH-1:0] r_rdata;

    // Read data holds while i_re is low; the read pipeline relies on this to stall.
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
        if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/axis_packet_fifo.sv
// Store-and-forward AXIS packet FIFO: frames leave only once fully buffered; frames that overflow are dropped.
// Define PKT_FIFO_DROP_CNT_EN to add the drop_count port and its saturating counter.
module axis_packet_fifo
    import pkt_fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int DEPTH_LOG2    = 10,
    parameter int MAX_PKTS_LOG2 = 4
) (
    input  logic                   axis_aclk,
    input  logic                   axis_aresetn,
    input  logic [DATA_WIDTH-1:0]  s_axis_tdata,
    input  logic                   s_axis_tvalid,
    output logic                   s_axis_tready,
    input  logic                   s_axis_tlast,
    output logic [DATA_WIDTH-1:0]  m_axis_tdata,
    output logic                   m_axis_tvalid,
    input  logic                   m_axis_tready,
    output logic                   m_axis_tlast,
    output logic [MAX_PKTS_LOG2:0] pkt_count,
    output logic [DEPTH_LOG2:0]    occupancy
`ifdef PKT_FIFO_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0]  drop_count
`endif
);
    localparam int PW = ptr_w(DEPTH_LOG2);
    localparam logic [PW-1:0]            DEPTH    = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [MAX_PKTS_LOG2:0]   MAX_PKTS = {1'b1, {MAX_PKTS_LOG2{1'b0}}};

    wr_state_t r_state, w_state_nxt;
    logic [PW-1:0] r_wr_cur, r_wr_commit, r_raddr, r_rd;
    logic [PW-1:0] w_wr_cur_nxt, w_rd_nxt;
    logic [MAX_PKTS_LOG2:0] r_pkt, w_pkt_nxt;
    logic [PW-1:0] r_occ;
    logic r_s_tready;
    logic w_s_hs, w_full, w_we, w_commit, w_drop;
    logic w_m_hs, w_pop_last, w_out_rdy, w_re;
    logic r_s1vld, r_ovld, r_olast;
    logic [DATA_WIDTH-1:0] r_odata;
    logic [DATA_WIDTH:0] w_rdata;

    assign w_s_hs = s_axis_tvalid & r_s_tready;
    // Full is measured against the handshake pointer so prefetched beats are never overwritten.
    assign w_full = (r_wr_cur - r_rd) == DEPTH;

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) r_state <= W_PASS;
        else               r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            W_PASS:  if (w_drop && !s_axis_tlast) w_state_nxt = W_DROP;
            W_DROP:  if (w_s_hs && s_axis_tlast)  w_state_nxt = W_PASS;
            default: w_state_nxt = W_PASS;
        endcase
    end

    always_comb begin
        w_we     = 1'b0;
        w_commit = 1'b0;
        w_drop   = 1'b0;
        if (r_state == W_PASS && w_s_hs) begin
            if (w_full) begin
                w_drop = 1'b1;
            end else begin
                w_we     = 1'b1;
                w_commit = s_axis_tlast;
            end
        end
    end

    assign w_m_hs     = r_ovld & m_axis_tready;
    assign w_pop_last = w_m_hs & r_olast;
    assign w_out_rdy  = ~r_ovld | m_axis_tready;
    assign w_re       = (r_raddr != r_wr_commit) & (~r_s1vld | w_out_rdy);

    assign w_wr_cur_nxt = w_drop ? r_wr_commit : (w_we ? r_wr_cur + 1'b1 : r_wr_cur);
    assign w_rd_nxt     = w_m_hs ? r_rd + 1'b1 : r_rd;

    always_comb begin
        w_pkt_nxt = r_pkt;
        if (w_commit && !w_pop_last)      w_pkt_nxt = r_pkt + 1'b1;
        else if (!w_commit && w_pop_last) w_pkt_nxt = r_pkt - 1'b1;
    end

    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            r_wr_cur    <= '0;
            r_wr_commit <= '0;
            r_rd        <= '0;
            r_pkt       <= '0;
            r_occ       <= '0;
            r_s_tready  <= 1'b0;
        end else begin
            r_wr_cur   <= w_wr_cur_nxt;
            r_rd       <= w_rd_nxt;
            r_pkt      <= w_pkt_nxt;
            r_occ      <= w_wr_cur_nxt - w_rd_nxt;
            r_s_tready <= (w_pkt_nxt != MAX_PKTS);
            if (w_commit) r_wr_commit <= r_wr_cur + 1'b1;
        end
    end

    // Two-stage read pipeline: RAM output register, then the AXIS output register.
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn) begin
            r_raddr <= '0;
            r_s1vld <= 1'b0;
            r_ovld  <= 1'b0;
            r_olast <= 1'b0;
            r_odata <= '0;
        end else begin
            if (w_re) r_raddr <= r_raddr + 1'b1;
            r_s1vld <= w_re | (r_s1vld & ~w_out_rdy);
            if (w_out_rdy) begin
                r_ovld <= r_s1vld;
                if (r_s1vld) {r_olast, r_odata} <= w_rdata;
            end
        end
    end

    pkt_fifo_ram #(
        .WIDTH (DATA_WIDTH + 1),
        .AW    (DEPTH_LOG2)
    ) u_ram (
        .i_clk   (axis_aclk),
        .i_we    (w_we),
        .i_waddr (r_wr_cur[DEPTH_LOG2-1:0]),
        .i_wdata ({s_axis_tlast, s_axis_tdata}),
        .i_re    (w_re),
        .i_raddr (r_raddr[DEPTH_LOG2-1:0]),
        .o_rdata (w_rdata)
    );

`ifdef PKT_FIFO_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] r_drop_cnt;
    always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
        if (!axis_aresetn)                    r_drop_cnt <= '0;
        else if (w_drop && r_drop_cnt != '1) r_drop_cnt <= r_drop_cnt + 1'b1;
    end
    assign drop_count = r_drop_cnt;
`endif

    assign s_axis_tready = r_s_tready;
    assign m_axis_tvalid = r_ovld;
    assign m_axis_tdata  = r_odata;
    assign m_axis_tlast  = r_olast;
    assign pkt_count     = r_pkt;
    assign occupancy     = r_occ;
endmodule

// File: tb/tb_axis_packet_fifo.sv
// Randomized and directed bench for axis_packet_fifo against a frame-level queue model.
// Define PKT_FIFO_DROP_CNT_EN to also check drop_count.
module tb_axis_packet_fifo;
    localparam int DW   = 32;
    localparam int DL   = 4;
    localparam int MPL  = 2;
    localparam int DEPTH = 1 << DL;
    localparam int MAXP  = 1 << MPL;

    logic clk, rst_n;
    logic [DW-1:0] s_tdata;
    logic s_tvalid, s_tlast, m_tready;
    logic s_axis_tready, m_axis_tvalid, m_axis_tlast;
    logic [DW-1:0] m_axis_tdata;
    logic [MPL:0] pkt_count;
    logic [DL:0]  occupancy;
`ifdef PKT_FIFO_DROP_CNT_EN
    logic [15:0] drop_count;
`endif

    axis_packet_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL), .MAX_PKTS_LOG2(MPL)) dut (
        .axis_aclk     (clk),
        .axis_aresetn  (rst_n),
        .s_axis_tdata  (s_tdata),
        .s_axis_tvalid (s_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_tlast),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_tready),
        .m_axis_tlast  (m_axis_tlast),
        .pkt_count     (pkt_count),
        .occupancy     (occupancy)
`ifdef PKT_FIFO_DROP_CNT_EN
        ,
        .drop_count    (drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: committed beats awaiting output, the frame being written, and frame bookkeeping.
    bit [DW:0] exp_q[$];
    bit [DW:0] cur[$];
    int  npkts, drops, pops;
    bit  dropping;
    bit  hold_pend;
    logic [DW:0] hold_beat;
    bit  obs_mvld, obs_srdy, last_acc;
    int  n_chk, n_fail;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        cur.delete();
        npkts = 0; drops = 0; dropping = 0; hold_pend = 0;
    endtask

    task automatic cycle(input bit sv, input logic [DW-1:0] sd, input bit sl, input bit mr);
        bit s_hs, m_hs, full;
        bit [DW:0] b;
        @(negedge clk);
        s_tvalid = sv; s_tdata = sd; s_tlast = sl; m_tready = mr;
        #1;
        obs_mvld = m_axis_tvalid;
        obs_srdy = s_axis_tready;
        chk("s_tready", s_axis_tready, npkts != MAXP);
        chk("pkt_count", pkt_count, npkts);
        chk("occupancy", occupancy, exp_q.size() + cur.size());
`ifdef PKT_FIFO_DROP_CNT_EN
        chk("drop_count", drop_count, drops);
`endif
        if (hold_pend) begin
            chk("hold_vld", m_axis_tvalid, 1);
            chk("hold_beat", {m_axis_tlast, m_axis_tdata}, hold_beat);
        end
        if (m_axis_tvalid) begin
            if (exp_q.size() == 0) chk("spurious_vld", m_axis_tvalid, 0);
            else                   chk("out_beat", {m_axis_tlast, m_axis_tdata}, exp_q[0]);
        end
        hold_pend = m_axis_tvalid && !mr;
        hold_beat = {m_axis_tlast, m_axis_tdata};
        s_hs = sv && s_axis_tready;
        m_hs = m_axis_tvalid && mr;
        last_acc = s_hs;
        full = (exp_q.size() + cur.size()) == DEPTH;
        if (m_hs && exp_q.size() != 0) begin
            b = exp_q.pop_front();
            pops++;
            if (b[DW]) npkts--;
        end
        if (s_hs) begin
            if (dropping) begin
                if (sl) dropping = 0;
            end else if (full) begin
                cur.delete();
                if (drops < 16'hFFFF) drops++;
                dropping = !sl;
            end else begin
                cur.push_back({sl, sd});
                if (sl) begin
                    foreach (cur[i]) exp_q.push_back(cur[i]);
                    cur.delete();
                    npkts++;
                end
            end
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(0, '0, 0, 1);
    endtask

    initial begin
        int len, idx, p0, guard;
        bit pend, pl, mr;
        logic [DW-1:0] pd;
        n_chk = 0; n_fail = 0; pops = 0;
        model_clear();
        s_tvalid = 0; s_tdata = '0; s_tlast = 0; m_tready = 0;
        rst_n = 0;
        repeat (3) @(negedge clk);
        chk("rst_mvld", m_axis_tvalid, 0);
        chk("rst_srdy", s_axis_tready, 0);
        chk("rst_pkt", pkt_count, 0);
        chk("rst_occ", occupancy, 0);
        rst_n = 1;
        repeat (2) @(negedge clk);

        // 1: single frame, latency and back-to-back output
        for (int i = 0; i < 4; i++) cycle(1, 32'h10 + i, i == 3, 1);
        cycle(0, '0, 0, 1); chk("t1_pkt", pkt_count, 1);
        cycle(0, '0, 0, 1); chk("t1_lat1", obs_mvld, 0);
        cycle(0, '0, 0, 1); chk("t1_lat2", obs_mvld, 1);
        for (int i = 0; i < 3; i++) begin cycle(0, '0, 0, 1); chk("t1_b2b", obs_mvld, 1); end
        cycle(0, '0, 0, 1); chk("t1_end", obs_mvld, 0);

        // 2: two frames under backpressure, then contiguous release
        for (int i = 0; i < 3; i++) cycle(1, 32'h20 + i, i == 2, 0);
        for (int i = 0; i < 3; i++) cycle(1, 32'h30 + i, i == 2, 0);
        for (int i = 0; i < 4; i++) cycle(0, '0, 0, 0);
        chk("t2_occ", occupancy, 6);
        chk("t2_pkt", pkt_count, 2);
        chk("t2_vld", obs_mvld, 1);
        for (int i = 0; i < 6; i++) begin cycle(0, '0, 0, 1); chk("t2_stream", obs_mvld, 1); end
        cycle(0, '0, 0, 1); chk("t2_done", obs_mvld, 0);

        // 3: oversize frame dropped, following frame intact
        p0 = pops;
        for (int i = 0; i < 20; i++) cycle(1, 32'h100 + i, i == 19, 1);
        cycle(0, '0, 0, 1);
        chk("t3_occ", occupancy, 0);
`ifdef PKT_FIFO_DROP_CNT_EN
        chk("t3_drops", drop_count, 1);
`endif
        cycle(1, 32'h200, 0, 1);
        cycle(1, 32'h201, 1, 1);
        drain(6);
        chk("t3_pops", pops - p0, 2);

        // 4: frame-count limit throttles the input
        for (int i = 0; i < MAXP; i++) cycle(1, 32'h40 + i, 1, 0);
        for (int i = 0; i < 3; i++) begin cycle(1, 32'h4F, 1, 0); chk("t4_block", obs_srdy, 0); end
        cycle(1, 32'h4F, 1, 1);
        cycle(1, 32'h4F, 1, 0); chk("t4_acc", last_acc, 1);
        drain(12);

        // 5: reset in the middle of input and output activity
        for (int i = 0; i < 3; i++) cycle(1, 32'h50 + i, i == 2, 0);
        cycle(1, 32'h60, 0, 0);
        cycle(1, 32'h61, 0, 0);
        @(negedge clk);
        s_tvalid = 0; m_tready = 0;
        rst_n = 0;
        #1;
        chk("t5_mvld", m_axis_tvalid, 0);
        chk("t5_mdata", m_axis_tdata, 0);
        chk("t5_mlast", m_axis_tlast, 0);
        chk("t5_srdy", s_axis_tready, 0);
        chk("t5_pkt", pkt_count, 0);
        chk("t5_occ", occupancy, 0);
        model_clear();
        repeat (2) @(negedge clk);
        rst_n = 1;
        repeat (2) @(negedge clk);
        p0 = pops;
        cycle(1, 32'h77, 1, 1);
        drain(5);
        chk("t5_pops", pops - p0, 1);

        // Random traffic: variable frame sizes, bursty backpressure
        len = 3; idx = 0; pend = 0; pl = 0; pd = '0;
        for (int c = 0; c < 4000; c++) begin
            if (!pend && ($urandom % 4 != 0)) begin
                pend = 1; pd = $urandom; pl = (idx == len - 1);
            end
            if (c % 500 < 150) mr = ($urandom % 8 == 0);
            else               mr = ($urandom % 4 != 0);
            cycle(pend, pd, pl, mr);
            if (last_acc) begin
                pend = 0;
                if (pl) begin
                    idx = 0;
                    len = ($urandom % 6 == 0) ? $urandom_range(12, 20) : $urandom_range(1, 6);
                end else idx++;
            end
        end
        guard = 0;
        while ((pend || idx != 0) && guard < 500) begin
            if (!pend) begin pend = 1; pd = $urandom; pl = (idx == len - 1); end
            cycle(1, pd, pl, 1);
            if (last_acc) begin pend = 0; if (pl) idx = 0; else idx++; end
            guard++;
        end
        guard = 0;
        while (exp_q.size() != 0 && guard < 300) begin cycle(0, '0, 0, 1); guard++; end
        drain(4);
        chk("end_occ", occupancy, 0);
        chk("end_mvld", obs_mvld, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
